// File: rtl/imem_loader.sv
// imem_loader: streams instruction words from a valid/ready source into
// consecutive instruction-memory addresses through arbiter port 2.
// Port 1 (fetch) always wins, so every request is held and re-presented
// until the arbiter stops reporting mem_busy.
// Optional feature: define IMEM_LOADER_VERIFY_EN to read each word back
// after writing it and flag any mismatch on verify_err.
module imem_loader #(
    parameter int PORTW     = 32,
    parameter int ADDRWIDTH = 7
) (
    input  logic                 clk,
    input  logic                 rstx,
    input  logic                 start,
    input  logic [ADDRWIDTH-1:0] start_addr,
    input  logic [ADDRWIDTH:0]   word_count,
    input  logic                 s_valid,
    input  logic [PORTW-1:0]     s_data,
    output logic                 s_ready,
    output logic                 load_busy,
    output logic                 load_done,
    output logic [PORTW-1:0]     d_2,
    output logic [ADDRWIDTH-1:0] addr_2,
    output logic                 en_2_x,
    output logic                 wr_2_x,
    output logic [PORTW-1:0]     bit_wr_2_x,
`ifdef IMEM_LOADER_VERIFY_EN
    input  logic [PORTW-1:0]     q,
    output logic                 verify_err,
`endif
    input  logic                 mem_busy
);

    typedef enum logic [2:0] {
        IDLE,
        WRITE,
        DONE
`ifdef IMEM_LOADER_VERIFY_EN
        ,
        READ,
        CHECK
`endif
    } state_t;

    state_t                 state;
    state_t                 next_state;
    logic [ADDRWIDTH-1:0]   cur_addr;
    logic [ADDRWIDTH:0]     acc_left;
    logic [ADDRWIDTH:0]     wr_left;
    logic [PORTW-1:0]       buf_data;
    logic                   buf_valid;
    logic                   wr_fire;
    logic                   word_retire;
    logic                   xfer;

    // Next-state logic and all port-2 / handshake outputs; every output is
    // decoded from the registered state so reset forces idle values at once.
    always_comb begin
        next_state  = state;
        s_ready     = 1'b0;
        en_2_x      = 1'b1;
        wr_2_x      = 1'b1;
        bit_wr_2_x  = '1;
        d_2         = '0;
        addr_2      = '0;
        wr_fire     = 1'b0;
        word_retire = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    next_state = (word_count == '0) ? DONE : WRITE;
                end
            end
            WRITE: begin
                if (buf_valid) begin
                    en_2_x     = 1'b0;
                    wr_2_x     = 1'b0;
                    bit_wr_2_x = '0;
                    addr_2     = cur_addr;
                    d_2        = buf_data;
                    wr_fire    = !mem_busy;
                end
`ifdef IMEM_LOADER_VERIFY_EN
                s_ready = (acc_left != '0) && !buf_valid;
                if (wr_fire) begin
                    next_state = READ;
                end
`else
                word_retire = wr_fire;
                s_ready     = (acc_left != '0) && (!buf_valid || wr_fire);
                if (wr_fire && (wr_left == (ADDRWIDTH+1)'(1))) begin
                    next_state = DONE;
                end
`endif
            end
`ifdef IMEM_LOADER_VERIFY_EN
            READ: begin
                en_2_x = 1'b0;
                addr_2 = cur_addr;
                if (!mem_busy) begin
                    next_state = CHECK;
                end
            end
            CHECK: begin
                word_retire = 1'b1;
                s_ready     = (acc_left != '0);
                next_state  = (wr_left == (ADDRWIDTH+1)'(1)) ? DONE : WRITE;
            end
`endif
            DONE: begin
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
        xfer = s_valid && s_ready;
    end

    assign load_busy = (state != IDLE);
    assign load_done = (state == DONE);

    // State register, address/count bookkeeping and the one-word buffer.
    always_ff @(posedge clk or negedge rstx) begin
        if (!rstx) begin
            state     <= IDLE;
            cur_addr  <= '0;
            acc_left  <= '0;
            wr_left   <= '0;
            buf_data  <= '0;
            buf_valid <= 1'b0;
        end else begin
            state <= next_state;
            if (state == IDLE) begin
                if (start) begin
                    cur_addr  <= start_addr;
                    acc_left  <= word_count;
                    wr_left   <= word_count;
                    buf_valid <= 1'b0;
                end
            end else begin
                if (word_retire) begin
                    cur_addr <= cur_addr + ADDRWIDTH'(1);
                    wr_left  <= wr_left - (ADDRWIDTH+1)'(1);
                end
                if (xfer) begin
                    buf_data  <= s_data;
                    buf_valid <= 1'b1;
                    acc_left  <= acc_left - (ADDRWIDTH+1)'(1);
                end else if (word_retire) begin
                    buf_valid <= 1'b0;
                end
            end
        end
    end

`ifdef IMEM_LOADER_VERIFY_EN
    // Sticky readback comparison, cleared only by reset or a new start.
    always_ff @(posedge clk or negedge rstx) begin
        if (!rstx) begin
            verify_err <= 1'b0;
        end else if ((state == IDLE) && start) begin
            verify_err <= 1'b0;
        end else if ((state == CHECK) && (q != buf_data)) begin
            verify_err <= 1'b1;
        end
    end
`endif

endmodule

// File: doc/imem_loader.md
# imem_loader

Testbench-side instruction memory loader that drives the secondary (write) port of the instruction memory arbiter. It accepts a stream of instruction words over a valid/ready handshake and writes them to consecutive imem addresses. Port 1 of the arbiter belongs to the core's fetch unit and always wins; this block holds each write and retries it until the arbiter reports the access taken. Used by ProGe testbenches to (re)load program images while the core is running or stalled.

## Interface
- PORTW, 32, instruction word width in bits
- ADDRWIDTH, 7, imem word-address width
- clk  in  1  clock; all state updates on rising edge
- rstx  in  1  reset; asynchronous, active-low
- start  in  1  one-cycle pulse, honoured only in IDLE
- start_addr  in  ADDRWIDTH  first word address, latched on start
- word_count  in  ADDRWIDTH+1  words to load, 0..2^ADDRWIDTH, latched on start
- s_valid  in  1  input word valid
- s_data  in  PORTW  input word
- s_ready  out  1  loader accepts s_data this cycle
- load_busy  out  1  high whenever state is not IDLE
- load_done  out  1  one-cycle pulse when the last word is written
- d_2  out  PORTW  write data to arbiter port 2
- addr_2  out  ADDRWIDTH  address to arbiter port 2
- en_2_x  out  1  port-2 enable, active-low
- wr_2_x  out  1  port-2 write strobe, active-low (0 = write)
- bit_wr_2_x  out  PORTW  port-2 bit write mask, active-low
- mem_busy  in  1  arbiter: port-2 request lost this cycle, retry
- q  in  PORTW  imem read data, valid one cycle after an accepted read (IMEM_LOADER_VERIFY_EN only)
- verify_err  out  1  sticky readback mismatch flag (IMEM_LOADER_VERIFY_EN only)

## Operation
- States: IDLE, WRITE, DONE; READ and CHECK added under IMEM_LOADER_VERIFY_EN.
- IDLE: s_ready=0, en_2_x=1. On start: latch start_addr into cur_addr, word_count into acc_left and wr_left; word_count=0 -> DONE, else -> WRITE.
- One-word holding buffer (buf, buf_valid). Handshake: word transfers when s_valid && s_ready.
- WRITE, buf_valid=1: en_2_x=0, wr_2_x=0, bit_wr_2_x=all 0, addr_2=cur_addr, d_2=buf. Write accepted iff mem_busy=0 that cycle; then cur_addr+1 (modulo 2^ADDRWIDTH, wraps 2^ADDRWIDTH-1 -> 0), wr_left-1, buf_valid cleared unless refilled in the same cycle.
- mem_busy=1: buf, addr, counters held; request re-presented next cycle unchanged. mem_busy ignored while en_2_x=1.
- s_ready = (acc_left != 0) && (!buf_valid || write accepted this cycle) in WRITE; acc_left decrements per transfer.
- wr_left reaching 0 -> DONE. DONE: load_done=1 for exactly one cycle, then IDLE.
- start outside IDLE ignored. s_valid with s_ready=0 never consumes data.
- When en_2_x=1: wr_2_x=1, bit_wr_2_x=all 1, d_2=0, addr_2=0.

## Timing
- Reset (rstx=0, immediate): state IDLE, s_ready=0, load_busy=0, load_done=0, en_2_x=1, wr_2_x=1, bit_wr_2_x=all 1, addr_2=0, d_2=0, verify_err=0, buffer/counters 0. Reset mid-load abandons the transfer; no partial write is issued after rstx falls.
- start at edge N -> load_busy=1, s_ready=1 in cycle N+1.
- Word accepted at edge N -> write request visible in cycle N+1; uncontended throughput 1 word/cycle.
- Last write accepted at edge N -> load_done high in cycle N+1, load_busy low from N+2.
- word_count=0: load_done in cycle after start, no memory access.

## Configuration
- IMEM_LOADER_VERIFY_EN defined: each word follows WRITE -> READ -> CHECK. READ: en_2_x=0, wr_2_x=1, addr_2=written address, retried while mem_busy=1. CHECK (cycle after accepted read): q != buf sets verify_err (sticky until reset or next start). s_ready only when buf empty; throughput 1 word/3 cycles uncontended. Ports q, verify_err present.
- Not defined: no READ/CHECK states, no q/verify_err ports, pipelined 1 word/cycle.

## Test plan
- start_addr=0x10, word_count=4, words 0xA0..0xA3, mem_busy=0 -> writes at 0x10..0x13 on 4 consecutive cycles, load_done one cycle after last.
- Same, mem_busy=1 for 3 cycles during word 2 -> addr_2=0x12, d_2=0xA2 held 4 cycles, s_ready=0 while held, no word lost or duplicated.
- start_addr=0x7E, word_count=4 -> addresses 0x7E, 0x7F, 0x00, 0x01.
- word_count=0 -> load_done next cycle, en_2_x never low; start during WRITE ignored.
- rstx low mid-load after 2 of 5 words -> all outputs at reset values immediately; new start loads cleanly.
- VERIFY_EN: memory model corrupts word at 0x11 -> verify_err=1 after its CHECK, remains 1 through load_done.
